// File: rtl/dlfloat_operand_loader_if.sv
// Byte-stream input and operand-pair output handshakes of the DLFloat16 operand loader.
// The DUT takes the slave view; the upstream producer and the MAC consumer take the master view.
interface dlfloat_operand_loader_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             frame_clr;
  logic [15:0]      pair_a;
  logic [15:0]      pair_b;
  logic             pair_valid;
  logic             pair_ready;
  logic             pair_nan;
  logic             pair_zero;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output byte_in, byte_valid, frame_clr, pair_ready,
    input  byte_ready, pair_a, pair_b, pair_valid, pair_nan, pair_zero, fifo_count
  );

  modport slave (
    input  byte_in, byte_valid, frame_clr, pair_ready,
    output byte_ready, pair_a, pair_b, pair_valid, pair_nan, pair_zero, fifo_count
  );
endinterface

// File: rtl/dlfloat_operand_loader.sv
// Assembles a byte stream into DLFloat16 (a, b) operand pairs and buffers them in a
// first-word-fall-through FIFO with NaN/zero flags decoded at the head.
module dlfloat_operand_loader #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  dlfloat_operand_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {A_HI, A_LO, B_HI, B_LO} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_a;
  logic [7:0]    r_b1;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_byte_ready;
  logic          w_accept;
  logic          w_take;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [15:0]   w_b;
  logic [31:0]   w_head;
  logic [15:0]   w_head_a;
  logic [15:0]   w_head_b;

  // Only the completing byte can stall; the first three always land in the partial register.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_byte_ready = !rst && ((r_state != B_LO) || !w_full);
  assign w_accept     = bus.byte_valid && w_byte_ready;
  assign w_take       = w_accept && !bus.frame_clr;
  assign w_push       = w_take && (r_state == B_LO);
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid && bus.pair_ready;
  assign w_b          = MSB_FIRST ? {r_b1, bus.byte_in} : {bus.byte_in, r_b1};

  always_ff @(posedge clk) begin
    if (rst) r_state <= A_HI;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.frame_clr) begin
      w_state_nxt = A_HI;
    end else if (w_accept) begin
      case (r_state)
        A_HI:    w_state_nxt = A_LO;
        A_LO:    w_state_nxt = B_HI;
        B_HI:    w_state_nxt = B_LO;
        default: w_state_nxt = A_HI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.frame_clr) begin
      r_a  <= '0;
      r_b1 <= '0;
    end else if (w_take) begin
      case (r_state)
        A_HI:    r_a  <= MSB_FIRST ? {bus.byte_in, 8'h00} : {8'h00, bus.byte_in};
        A_LO:    r_a  <= MSB_FIRST ? {r_a[15:8], bus.byte_in} : {bus.byte_in, r_a[7:0]};
        B_HI:    r_b1 <= bus.byte_in;
        default: begin
          r_a  <= '0;
          r_b1 <= '0;
        end
      endcase
    end
  end

  // FIFO storage carries no reset: empty entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_a, w_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head   = r_mem[r_rptr];
  assign w_head_a = w_valid ? w_head[31:16] : 16'h0000;
  assign w_head_b = w_valid ? w_head[15:0]  : 16'h0000;

  assign bus.byte_ready = w_byte_ready;
  assign bus.pair_a     = w_head_a;
  assign bus.pair_b     = w_head_b;
  assign bus.pair_valid = w_valid;
  assign bus.pair_nan   = w_valid && ((w_head_a == 16'hFFFF) || (w_head_b == 16'hFFFF));
  assign bus.pair_zero  = w_valid && ((w_head_a == 16'h0000) || (w_head_b == 16'h0000));
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Bench for dlfloat_operand_loader: MSB-first and LSB-first instances run in lockstep on the
// same operand stream and are both scored against one queue of expected pairs.
module tb_dlfloat_operand_loader;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic       frame_clr;
  logic       pair_ready;
  logic [7:0] b1_in;
  logic [7:0] b0_in;

  always #5 clk = ~clk;

  dlfloat_operand_loader_if #(.DEPTH(DEPTH)) bus1 ();
  dlfloat_operand_loader_if #(.DEPTH(DEPTH)) bus0 ();

  assign bus1.byte_in    = b1_in;
  assign bus1.byte_valid = byte_valid;
  assign bus1.frame_clr  = frame_clr;
  assign bus1.pair_ready = pair_ready;
  assign bus0.byte_in    = b0_in;
  assign bus0.byte_valid = byte_valid;
  assign bus0.frame_clr  = frame_clr;
  assign bus0.pair_ready = pair_ready;

  dlfloat_operand_loader #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus1));
  dlfloat_operand_loader #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus0));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] q[$];
  int          pos     = 0;
  logic [7:0]  fb[4];
  bit          mon_en  = 1'b0;
  bit          pr_rand = 1'b0;
  int          stalls  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares the head of the expected queue with both DUTs each cycle.
  always @(negedge clk) begin
    logic [31:0] h;
    bit          ev;
    logic        exp_rdy;
    if (mon_en) begin
      ev      = (q.size() != 0);
      h       = ev ? q[0] : 32'h0;
      exp_rdy = !rst && !((pos == 3) && (q.size() == DEPTH));
      check("count_msb", 32'(bus1.fifo_count), q.size());
      check("count_lsb", 32'(bus0.fifo_count), q.size());
      check("valid_msb", 32'(bus1.pair_valid), 32'(ev));
      check("valid_lsb", 32'(bus0.pair_valid), 32'(ev));
      check("a_msb", 32'(bus1.pair_a), 32'(h[31:16]));
      check("b_msb", 32'(bus1.pair_b), 32'(h[15:0]));
      check("a_lsb", 32'(bus0.pair_a), 32'(h[31:16]));
      check("b_lsb", 32'(bus0.pair_b), 32'(h[15:0]));
      check("nan_msb", 32'(bus1.pair_nan), 32'(ev && (h[31:16] == 16'hFFFF || h[15:0] == 16'hFFFF)));
      check("nan_lsb", 32'(bus0.pair_nan), 32'(ev && (h[31:16] == 16'hFFFF || h[15:0] == 16'hFFFF)));
      check("zero_msb", 32'(bus1.pair_zero), 32'(ev && (h[31:16] == 16'h0 || h[15:0] == 16'h0)));
      check("zero_lsb", 32'(bus0.pair_zero), 32'(ev && (h[31:16] == 16'h0 || h[15:0] == 16'h0)));
      check("ready_msb", 32'(bus1.byte_ready), 32'(exp_rdy));
      check("ready_lsb", 32'(bus0.byte_ready), 32'(exp_rdy));
      if (ev && pair_ready) void'(q.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pr_rand) pair_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst        = 1'b1;
    byte_valid = 1'b0;
    frame_clr  = 1'b0;
    @(posedge clk);
    q.delete();
    pos = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // One byte in arrival order: v1 for the MSB-first DUT, v0 for the LSB-first DUT.
  task automatic send_byte(input logic [7:0] v1, input logic [7:0] v0, input bit clr, output int waits);
    int   n    = 0;
    bit   done = 1'b0;
    logic rdy;
    b1_in = v1; b0_in = v0; byte_valid = 1'b1; frame_clr = clr;
    while (!done) begin
      @(negedge clk);
      rdy = bus1.byte_ready;
      @(posedge clk);
      if (clr) begin
        pos  = 0;
        done = 1'b1;
      end else if (rdy) begin
        fb[pos] = v1;
        if (pos == 3) begin
          q.push_back({fb[0], fb[1], fb[2], fb[3]});
          pos = 0;
        end else begin
          pos++;
        end
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          n_tests++; n_fail++;
          $display("FAIL byte_accept_timeout: got stalled %0d cycles expected accept", n);
          done = 1'b1;
        end
      end
    end
    #1 byte_valid = 1'b0; frame_clr = 1'b0;
    waits = n;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input int nbytes,
                            input bit clr_last, input bit gap);
    logic [15:0] op;
    logic [7:0]  v1, v0;
    int          w;
    for (int k = 0; k < nbytes; k++) begin
      op = (k < 2) ? a : b;
      v1 = (k % 2 == 0) ? op[15:8] : op[7:0];
      v0 = (k % 2 == 0) ? op[7:0]  : op[15:8];
      if (gap && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_byte(v1, v0, clr_last && (k == nbytes - 1), w);
      stalls += w;
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    byte_valid = 1'b0; frame_clr = 1'b0; pair_ready = 1'b0; b1_in = '0; b0_in = '0; rst = 1'b1;
    do_reset();

    // Single pair, consumer ready: visible one cycle later, then popped.
    pair_ready = 1'b1;
    send_frame(16'h3E00, 16'h4000, 4, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_valid", 32'(bus1.pair_valid), 32'd1);
    check("t1_a", 32'(bus1.pair_a), 32'h3E00);
    check("t1_b_lsb", 32'(bus0.pair_b), 32'h4000);
    @(negedge clk);
    check("t1_count", 32'(bus1.fifo_count), 32'd0);

    // Fill the FIFO, stall the fifth completing byte, release with a one-cycle pop.
    idle(1);
    pair_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(rnd16(), rnd16(), 4, 1'b0, 1'b0);
    send_frame(16'h1234, 16'h5678, 3, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_full", 32'(bus1.fifo_count), 32'd4);
    check("t2_stall", 32'(bus1.byte_ready), 32'd0);
    #6;
    fork
      send_byte(8'h78, 8'h56, 1'b0, w);
      begin
        repeat (3) @(posedge clk);
        #1 pair_ready = 1'b1;
        @(posedge clk);
        #1 pair_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("t2_refill", 32'(bus1.fifo_count), 32'd4);
    #6 pair_ready = 1'b1;
    idle(8);
    pair_ready = 1'b0;

    // Special operands flagged together.
    send_frame(16'hFFFF, 16'h0000, 4, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_nan", 32'(bus1.pair_nan), 32'd1);
    check("t3_zero", 32'(bus0.pair_zero), 32'd1);
    #6 pair_ready = 1'b1;
    idle(3);
    pair_ready = 1'b0;

    // frame_clr on the completing byte drops it; only the next frame appears.
    send_frame(16'h3E00, 16'h4000, 4, 1'b1, 1'b0);
    send_frame(16'h4200, 16'h3E00, 4, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_count", 32'(bus1.fifo_count), 32'd1);
    check("t4_a", 32'(bus0.pair_a), 32'h4200);
    #6 pair_ready = 1'b1;
    idle(3);
    pair_ready = 1'b0;

    // Reset with stored pairs and a partial frame, then a clean frame.
    send_frame(rnd16(), rnd16(), 4, 1'b0, 1'b0);
    send_frame(rnd16(), rnd16(), 4, 1'b0, 1'b0);
    send_frame(16'hAAAA, 16'hBBBB, 2, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    check("t5_count", 32'(bus1.fifo_count), 32'd0);
    check("t5_valid", 32'(bus0.pair_valid), 32'd0);
    #6;
    send_frame(16'h3C00, 16'hC000, 4, 1'b0, 1'b0);
    pair_ready = 1'b1;
    idle(3);

    // Back-to-back frames with a ready consumer never stall.
    stalls = 0;
    send_frame(16'h3E00, 16'h4000, 4, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_frame(rnd16(), rnd16(), 4, 1'b0, 1'b0);
    check("t6_stalls", 32'(stalls), 32'd0);
    idle(3);

    // Randomized traffic: gaps, random consumer, occasional aborted frames.
    pr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        send_frame(rnd16(), rnd16(), $urandom_range(1, 4), 1'b1, 1'b1);
      else
        send_frame(rnd16(), rnd16(), 4, 1'b0, 1'b1);
    end
    pr_rand = 1'b0;
    idle(1);
    pair_ready = 1'b1;
    idle(12);
    @(negedge clk);
    check("final_empty", 32'(bus1.fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
